// File: rtl/merger_tree_pkg.sv
// Shared helpers for the N-input sorted merge tree: key extraction and
// elaboration-time parameter legality checks.
package merger_tree_pkg;

    localparam int MAX_INPUTS = 32;
    localparam int MAX_WORD_W = 64;

    // Extracts the unsigned key field [msb:lsb] from a word of up to 64 bits.
    function automatic logic [31:0] key_of(
        input logic [63:0] word,
        input int          msb,
        input int          lsb
    );
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = word >> lsb;
        mask    = (64'd1 << (msb - lsb + 1)) - 64'd1;
        return 32'(shifted & mask);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit params_ok(
        input int data_width,
        input int active_msb,
        input int active_lsb,
        input int n_inputs
    );
        return is_pow2(n_inputs)
            && (n_inputs <= MAX_INPUTS)
            && (active_lsb >= 0)
            && (active_lsb <= active_msb)
            && (active_msb < data_width)
            && (active_msb - active_lsb < 32)
            && (data_width + $clog2(n_inputs) <= MAX_WORD_W);
    endfunction

endpackage

// File: rtl/merger_node.sv
// Two-input sorted merge stage with one registered output word. The word with
// the smaller key wins; ties go to input A, which always carries lower channels.
module merger_node
    import merger_tree_pkg::*;
#(
    parameter int W       = 15,
    parameter int KEY_MSB = 11,
    parameter int KEY_LSB = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] a_data,
    input  logic         a_valid,
    input  logic [W-1:0] b_data,
    input  logic         b_valid,
    input  logic         read,
    output logic         pop_a,
    output logic         pop_b,
    output logic [W-1:0] data,
    output logic         valid
);

    logic [W-1:0] data_r;
    logic         valid_r;
    logic [W-1:0] sel_data_s;
    logic         load_s;
    logic         a_wins_s;
    logic [31:0]  key_a_s;
    logic [31:0]  key_b_s;

    assign key_a_s = key_of(64'(a_data), KEY_MSB, KEY_LSB);
    assign key_b_s = key_of(64'(b_data), KEY_MSB, KEY_LSB);

    // Pick at most one input to pop when the register is free or being drained.
    always_comb begin
        load_s     = 1'b0;
        a_wins_s   = 1'b0;
        pop_a      = 1'b0;
        pop_b      = 1'b0;
        sel_data_s = a_data;
        if (en && (!valid_r || read)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        if (a_valid && (!b_valid || (key_a_s <= key_b_s))) begin
            a_wins_s = 1'b1;
        end else begin
            a_wins_s = 1'b0;
        end
        if (load_s && a_wins_s) begin
            pop_a      = 1'b1;
            sel_data_s = a_data;
        end else if (load_s && b_valid) begin
            pop_b      = 1'b1;
            sel_data_s = b_data;
        end else begin
            pop_a      = 1'b0;
            pop_b      = 1'b0;
            sel_data_s = a_data;
        end
    end

    // Output register: load the winner, or go empty once drained with nothing to take.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (pop_a || pop_b) begin
            data_r  <= sel_data_s;
            valid_r <= 1'b1;
        end else if (load_s) begin
            data_r  <= data_r;
            valid_r <= 1'b0;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

    assign data  = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/merger_tree.sv
// Parametrised N-input sorted merge tree built from merger_node stages.
// Optional output word counter enabled by defining MERGER_TREE_COUNT_EN.
module merger_tree
    import merger_tree_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ACTIVE_MSB = 11,
    parameter int ACTIVE_LSB = 6,
    parameter int N_INPUTS   = 8,
    parameter int IDX_W      = $clog2(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] inputs,
    input  logic [N_INPUTS-1:0]            valids,
    output logic [N_INPUTS-1:0]            outreads,
    input  logic                           inRead,
    output logic [DATA_WIDTH-1:0]          out,
    output logic                           vout,
    output logic [IDX_W-1:0]               input_index
`ifdef MERGER_TREE_COUNT_EN
    ,
    output logic [15:0]                    out_count
`endif
);

    localparam int LEVELS = $clog2(N_INPUTS);
    localparam int NODES  = N_INPUTS - 1;
    localparam int IW     = DATA_WIDTH + IDX_W;

    if (!params_ok(DATA_WIDTH, ACTIVE_MSB, ACTIVE_LSB, N_INPUTS) ||
        (IDX_W != $clog2(N_INPUTS))) begin : g_param_check
        $error("merger_tree: illegal parameter combination");
    end

    // Nodes are heap-indexed: node 0 is the root, children of j are 2j+1 (A) and 2j+2 (B).
    logic [IW-1:0]       node_data_s  [NODES];
    logic                node_valid_s [NODES];
    logic                node_read_s  [NODES];
    logic                pop_a_s      [NODES];
    logic                pop_b_s      [NODES];
    logic [N_INPUTS-1:0] pops_s;

    assign node_read_s[0] = inRead;

    for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_level
        for (genvar m = 0; m < (1 << lvl); m++) begin : g_node
            localparam int J = (1 << lvl) - 1 + m;

            logic [IW-1:0] a_data_s;
            logic [IW-1:0] b_data_s;
            logic          a_valid_s;
            logic          b_valid_s;

            if (lvl == LEVELS - 1) begin : g_leaf
                // The channel number is attached here and rides above the payload to the root.
                assign a_data_s  = {IDX_W'(2 * m),
                                    inputs[(2 * m) * DATA_WIDTH +: DATA_WIDTH]};
                assign b_data_s  = {IDX_W'(2 * m + 1),
                                    inputs[(2 * m + 1) * DATA_WIDTH +: DATA_WIDTH]};
                assign a_valid_s = valids[2 * m];
                assign b_valid_s = valids[2 * m + 1];
                assign pops_s[2 * m]     = pop_a_s[J];
                assign pops_s[2 * m + 1] = pop_b_s[J];
            end else begin : g_inner
                assign a_data_s  = node_data_s[2 * J + 1];
                assign b_data_s  = node_data_s[2 * J + 2];
                assign a_valid_s = node_valid_s[2 * J + 1];
                assign b_valid_s = node_valid_s[2 * J + 2];
                assign node_read_s[2 * J + 1] = pop_a_s[J];
                assign node_read_s[2 * J + 2] = pop_b_s[J];
            end

            merger_node #(
                .W       (IW),
                .KEY_MSB (ACTIVE_MSB),
                .KEY_LSB (ACTIVE_LSB)
            ) u_node (
                .clk     (clk),
                .reset   (reset),
                .en      (en),
                .a_data  (a_data_s),
                .a_valid (a_valid_s),
                .b_data  (b_data_s),
                .b_valid (b_valid_s),
                .read    (node_read_s[J]),
                .pop_a   (pop_a_s[J]),
                .pop_b   (pop_b_s[J]),
                .data    (node_data_s[J]),
                .valid   (node_valid_s[J])
            );
        end
    end

    // Source pops are suppressed while reset is held so no word is lost on entry.
    always_comb begin
        outreads = '0;
        if (reset) begin
            outreads = pops_s;
        end else begin
            outreads = '0;
        end
    end

    assign out         = node_data_s[0][DATA_WIDTH-1:0];
    assign input_index = node_data_s[0][IW-1:DATA_WIDTH];
    assign vout        = node_valid_s[0];

`ifdef MERGER_TREE_COUNT_EN
    logic [15:0] count_r;

    // Counts words accepted downstream; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 16'd0;
        end else if (en && vout && inRead) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign out_count = count_r;
`endif

endmodule

// File: doc/merger_tree.md
# merger_tree

Parametrised N-input sorted merge tree. Successor of the fixed four-input, two-level merger: channel count is a parameter, and the tree depth and source-index width derive from it. Pops words from N FIFO-style sources and emits one stream in ascending order of a key field, tagged with the originating channel. Sits between the per-channel stub/projection memories and the single-stream consumer (match engine / track builder).

## Interface
- DATA_WIDTH, 12, payload width per channel.
- ACTIVE_MSB, 11, key field upper bit within payload.
- ACTIVE_LSB, 6, key field lower bit within payload.
- N_INPUTS, 8, channel count; power of two, 2..32.
- IDX_W, $clog2(N_INPUTS), derived; not overridden.

Ports:
- clk  in  1  single clock, all logic rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- en  in  1  global enable; low freezes every register and strobe.
- inputs  in  N_INPUTS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valids  in  N_INPUTS  channel i has a word available.
- outreads  out  N_INPUTS  pop strobe to channel i; word on inputs[i] is consumed in that cycle.
- inRead  in  1  downstream pop strobe for current output word.
- out  out  DATA_WIDTH  merged payload, registered.
- vout  out  1  out/input_index hold a valid word.
- input_index  out  IDX_W  source channel of out.

## Operation
- Tree of merger_node instances, N_INPUTS-1 nodes, log2(N_INPUTS) levels. Leaf node k takes channels 2k, 2k+1; each channel index is appended above the payload at the leaves, so internal width is DATA_WIDTH+IDX_W and the index propagates untouched.
- Node: one output register plus valid bit. Node pops an input when en=1 and (register empty or inRead to the node is high) and at least one input valid.
- Selection: both valid -> smaller key (unsigned compare of bits ACTIVE_MSB:ACTIVE_LSB) wins; equal keys -> input A (lower channel) wins. Only one valid -> that one is forwarded without waiting.
- Only one outread per node per cycle; loser stays at its source.
- Register empty and no input valid -> vout of node drops if it was read this cycle.
- en=0: no pops, no register updates, outreads all 0, inRead ignored.
- Output order is sorted across channels only while all sources present words concurrently; a late source word is emitted in arrival order.

## Timing
- Reset (asserted asynchronously): out=0, input_index=0, vout=0, every node register invalid; outreads are 0 while reset is low.
- Latency from pop at a channel to word on out: log2(N_INPUTS) cycles with downstream never stalling (3 cycles for N_INPUTS=8).
- Throughput: one word per cycle at out when inRead held high and sources never empty.
- outreads is combinational from valids, node state and inRead; no combinational path from inputs payload to outreads other than through the key compare.
- Backpressure: inRead low holds out/vout/input_index stable; stall reaches level k after k cycles of full registers; no word lost or duplicated.
- Reset mid-stream: all in-flight words discarded; upstream pops in that cycle are not issued.

## Configuration
- MERGER_TREE_COUNT_EN defined: adds output out_count, 16 bits, reset 0, increments on every cycle with vout=1 and inRead=1 and en=1, wraps 0xFFFF -> 0.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Package merger_tree_pkg: key-extract function, parameter legality checks (power of two, ACTIVE_MSB < DATA_WIDTH, ACTIVE_LSB <= ACTIVE_MSB).
- Sub-module merger_node: two-input sorted merge stage with registered output, generic in width and key field; the tree is a generate loop over levels.

## Test plan
- Reset low with valids all 1 -> outreads=0, vout=0, out=0; release -> first word on out 3 cycles after first pop (N=8).
- N=8, channel i holds keys {i, i+8, i+16}, inRead=1 -> out keys 0..23 ascending, input_index = key mod 8.
- Channels 2 and 5 both present key 0x07 -> channel 2 emitted first, then 5.
- inRead held low 10 cycles during full stream -> out stable, no outreads after tree fills (7 words held), release -> no loss, no duplication.
- en=0 for 4 cycles mid-stream -> all outputs and outreads frozen/zero; resumes with same sequence.
- MERGER_TREE_COUNT_EN, 24 words read -> out_count=24; preset near 0xFFFF -> wraps to 0.
